// File: rtl/mitm_pkg.sv
// Shared definitions for the MITM select path: lane state encoding and select values.
// Also used by the output mux bench.
package mitm_pkg;

    typedef enum logic {
        LANE_SETTLED = 1'b0,
        LANE_PENDING = 1'b1
    } lane_state_e;

    localparam logic SEL_PASS   = 1'b0;
    localparam logic SEL_INJECT = 1'b1;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val <= 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mitm_select_lane.sv
// One select lane: waits for its two sources to agree for SETTLE_CYCLES edges
// (or for the timeout) before flipping its select bit, with done/forced pulses.
module mitm_select_lane
    import mitm_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic freeze_i,
    input  logic line0_i,
    input  logic line1_i,
    output logic select_o,
    output logic done_o,
    output logic forced_o,
    output logic pending_o
);

    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned MATCH_W    = cnt_width(SETTLE_CYCLES - 1);
    localparam int unsigned WAIT_W     = TIMEOUT_EN ? cnt_width(TIMEOUT_CYCLES - 1) : 1;

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SETTLE_CYCLES - 1);
    // Without a timeout the wait counter simply parks at all-ones.
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = TIMEOUT_EN ? WAIT_W'(TIMEOUT_CYCLES - 1) : '1;

    lane_state_e        state_q, state_d;
    logic               select_q, select_d;
    logic               done_q, done_d;
    logic               forced_q, forced_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic equal;
    logic withdrawn;

    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        match_d   = match_q;
        wait_d    = wait_q;
        done_d    = 1'b0;
        forced_d  = 1'b0;
        equal     = (line0_i == line1_i);
        withdrawn = (req_i == select_q);

        unique case (state_q)
            LANE_SETTLED: begin
                if (!freeze_i && !withdrawn) begin
                    state_d = LANE_PENDING;
                    match_d = '0;
                    wait_d  = '0;
                end
            end
            LANE_PENDING: begin
                // Withdrawal is honoured even while frozen.
                if (withdrawn) begin
                    state_d = LANE_SETTLED;
                    match_d = '0;
                    wait_d  = '0;
                end else if (!freeze_i) begin
                    if (equal && (match_q == MATCH_LAST)) begin
                        state_d  = LANE_SETTLED;
                        select_d = ~select_q;
                        done_d   = 1'b1;
                        match_d  = '0;
                        wait_d   = '0;
                    end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
                        state_d  = LANE_SETTLED;
                        select_d = ~select_q;
                        done_d   = 1'b1;
                        forced_d = 1'b1;
                        match_d  = '0;
                        wait_d   = '0;
                    end else begin
                        if (!equal) begin
                            match_d = '0;
                        end else if (match_q != MATCH_LAST) begin
                            match_d = match_q + MATCH_W'(1);
                        end
                        if (wait_q != WAIT_LAST) begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = LANE_SETTLED;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= LANE_SETTLED;
            select_q <= SEL_PASS;
            done_q   <= 1'b0;
            forced_q <= 1'b0;
            match_q  <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            done_q   <= done_d;
            forced_q <= forced_d;
            match_q  <= match_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        select_o  = select_q;
        done_o    = done_q;
        forced_o  = forced_q;
        pending_o = (state_q == LANE_PENDING);
    end

endmodule

// File: rtl/mitm_select_ctrl.sv
// Per-line select controller for the MITM output mux: one independent lane per bus line,
// busy is the OR of all lanes currently pending.
module mitm_select_ctrl
    import mitm_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_line,
    input  logic             freeze,
    input  logic [WIDTH-1:0] in_line0,
    input  logic [WIDTH-1:0] in_line1,
    output logic [WIDTH-1:0] select_line,
    output logic [WIDTH-1:0] switch_done,
    output logic [WIDTH-1:0] forced,
    output logic             busy
);

    logic [WIDTH-1:0] lane_pending;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        mitm_select_lane #(
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_lane (
            .clk_i    (sys_clk),
            .rst_i    (rst),
            .req_i    (req_line[g]),
            .freeze_i (freeze),
            .line0_i  (in_line0[g]),
            .line1_i  (in_line1[g]),
            .select_o (select_line[g]),
            .done_o   (switch_done[g]),
            .forced_o (forced[g]),
            .pending_o(lane_pending[g])
        );
    end

    always_comb begin
        busy = |lane_pending;
    end

endmodule

// File: tb/tb_mitm_select_ctrl.sv
// Self-checking bench for mitm_select_ctrl: directed vector table, hand-written
// multi-cycle corner sequences, then randomized traffic against a reference model.
module tb_mitm_select_ctrl;

    localparam int W       = 4;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;

    logic         sys_clk;
    logic         rst;
    logic [W-1:0] req_line;
    logic         freeze;
    logic [W-1:0] in_line0;
    logic [W-1:0] in_line1;
    logic [W-1:0] select_line;
    logic [W-1:0] switch_done;
    logic [W-1:0] forced;
    logic         busy;

    int tests;
    int failed;

    mitm_select_ctrl #(
        .WIDTH         (W),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .req_line   (req_line),
        .freeze     (freeze),
        .in_line0   (in_line0),
        .in_line1   (in_line1),
        .select_line(select_line),
        .switch_done(switch_done),
        .forced     (forced),
        .busy       (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic         rst;
        logic [W-1:0] req;
        logic         frz;
        logic [W-1:0] l0;
        logic [W-1:0] l1;
        logic [W-1:0] sel;
        logic [W-1:0] done;
        logic [W-1:0] frc;
        logic         busy;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [W-1:0] rq, input logic f,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] s, input logic [W-1:0] d,
                                input logic [W-1:0] fc, input logic bz);
        vec_t v;
        v.rst = r; v.req = rq; v.frz = f; v.l0 = a; v.l1 = b;
        v.sel = s; v.done = d; v.frc = fc; v.busy = bz;
        return v;
    endfunction

    // Reference model: natural-number bookkeeping of how long each lane has been
    // waiting and how long its sources have agreed since the request arrived.
    logic [W-1:0] m_sel, m_done, m_forced;
    logic         m_busy;
    bit           m_pend [W];
    int           m_run  [W];
    int           m_age  [W];

    task automatic model_step();
        m_done   = '0;
        m_forced = '0;
        if (rst) begin
            m_sel = '0;
            for (int i = 0; i < W; i++) begin
                m_pend[i] = 0; m_run[i] = 0; m_age[i] = 0;
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                if (!m_pend[i]) begin
                    if (!freeze && req_line[i] != m_sel[i]) begin
                        m_pend[i] = 1; m_run[i] = 0; m_age[i] = 0;
                    end
                end else if (req_line[i] == m_sel[i]) begin
                    m_pend[i] = 0;
                end else if (!freeze) begin
                    m_age[i]++;
                    m_run[i] = (in_line0[i] == in_line1[i]) ? m_run[i] + 1 : 0;
                    if (m_run[i] >= SETTLE) begin
                        m_sel[i] = req_line[i]; m_done[i] = 1'b1; m_pend[i] = 0;
                    end else if (TIMEOUT != 0 && m_age[i] >= TIMEOUT) begin
                        m_sel[i] = req_line[i]; m_done[i] = 1'b1; m_forced[i] = 1'b1; m_pend[i] = 0;
                    end
                end
            end
        end
        m_busy = 1'b0;
        for (int i = 0; i < W; i++) if (m_pend[i]) m_busy = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [W-1:0] s, input logic [W-1:0] d,
                           input logic [W-1:0] fc, input logic bz);
        chk({nm, "_sel"},    select_line, s);
        chk({nm, "_done"},   switch_done, d);
        chk({nm, "_forced"}, forced, fc);
        chk({nm, "_busy"},   {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, bz});
    endtask

    // Drive inputs, let one rising edge pass, and return just after it.
    task automatic apply(input logic r, input logic [W-1:0] rq, input logic f,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        rst = r; req_line = rq; freeze = f; in_line0 = a; in_line1 = b;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst = 1'b1; req_line = '0; freeze = 1'b0; in_line0 = '0; in_line1 = '0;

        // reset, settle-based flip, equal/differ/equal run, withdrawal
        vecs[0]  = mk(1, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[1]  = mk(1, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[2]  = mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        vecs[3]  = mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        vecs[4]  = mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0);
        vecs[5]  = mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0);
        vecs[6]  = mk(0, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1);
        vecs[7]  = mk(0, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1);
        vecs[8]  = mk(0, 4'b0101, 0, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1);
        vecs[9]  = mk(0, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1);
        vecs[10] = mk(0, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0101, 4'b0100, 4'b0000, 0);
        vecs[11] = mk(0, 4'b1101, 0, 4'b1000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1);
        vecs[12] = mk(0, 4'b1101, 0, 4'b1000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1);
        vecs[13] = mk(0, 4'b1101, 0, 4'b1000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1);
        vecs[14] = mk(0, 4'b0101, 0, 4'b1000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].frz, vecs[i].l0, vecs[i].l1);
            chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].done, vecs[i].frc, vecs[i].busy);
        end

        // Timeout on lane 1: sources never agree, flip forced on the 16th pending edge.
        apply(0, 4'b0111, 0, 4'b0010, 4'b0000);
        chk_all("to_entry", 4'b0101, 4'b0000, 4'b0000, 1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            apply(0, 4'b0111, 0, 4'b0010, 4'b0000);
            if (k < TIMEOUT) chk_all($sformatf("to_wait%0d", k), 4'b0101, 4'b0000, 4'b0000, 1);
            else             chk_all("to_fire", 4'b0111, 4'b0010, 4'b0010, 0);
        end
        apply(0, 4'b0111, 0, 4'b0010, 4'b0000);
        chk_all("to_after", 4'b0111, 4'b0000, 4'b0000, 0);

        // Freeze for 5 cycles during a settle wait delays the flip by 5 edges.
        apply(1, 4'b0000, 0, 4'b0000, 4'b0000);
        apply(0, 4'b0001, 0, 4'b0000, 4'b0000);
        chk_all("fz_entry", 4'b0000, 4'b0000, 4'b0000, 1);
        for (int k = 0; k < 5; k++) begin
            apply(0, 4'b0001, 1, 4'b0000, 4'b0000);
            chk_all($sformatf("fz_hold%0d", k), 4'b0000, 4'b0000, 4'b0000, 1);
        end
        apply(0, 4'b0001, 0, 4'b0000, 4'b0000);
        chk_all("fz_e1", 4'b0000, 4'b0000, 4'b0000, 1);
        apply(0, 4'b0001, 0, 4'b0000, 4'b0000);
        chk_all("fz_flip", 4'b0001, 4'b0001, 4'b0000, 0);

        // Reset mid-pending aborts the switch; afterwards the full wait restarts.
        apply(1, 4'b0000, 0, 4'b0000, 4'b0000);
        apply(0, 4'b0001, 0, 4'b0000, 4'b0000);
        apply(0, 4'b0001, 0, 4'b0000, 4'b0000);
        chk_all("rs_pre", 4'b0000, 4'b0000, 4'b0000, 1);
        apply(1, 4'b0001, 0, 4'b0000, 4'b0000);
        chk_all("rs_abort", 4'b0000, 4'b0000, 4'b0000, 0);
        apply(0, 4'b0001, 0, 4'b0000, 4'b0000);
        chk_all("rs_entry", 4'b0000, 4'b0000, 4'b0000, 1);
        apply(0, 4'b0001, 0, 4'b0000, 4'b0000);
        chk_all("rs_e1", 4'b0000, 4'b0000, 4'b0000, 1);
        apply(0, 4'b0001, 0, 4'b0000, 4'b0000);
        chk_all("rs_flip", 4'b0001, 4'b0001, 4'b0000, 0);

        // Settle completes on the same edge the timeout would fire: not forced.
        apply(1, 4'b0000, 0, 4'b0000, 4'b0000);
        apply(0, 4'b0100, 0, 4'b0100, 4'b0000);
        for (int k = 1; k <= 14; k++) apply(0, 4'b0100, 0, 4'b0100, 4'b0000);
        apply(0, 4'b0100, 0, 4'b0000, 4'b0000);
        chk_all("tie_e15", 4'b0000, 4'b0000, 4'b0000, 1);
        apply(0, 4'b0100, 0, 4'b0000, 4'b0000);
        chk_all("tie_e16", 4'b0100, 4'b0100, 4'b0000, 0);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        model_step();
        @(posedge sys_clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 199) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 11) == 0) req_line[b] = ~req_line[b];
            in_line0 = W'($urandom);
            in_line1 = ($urandom_range(0, 2) == 0) ? W'($urandom) : in_line0;
            model_step();
            @(posedge sys_clk);
            #1;
            chk_all($sformatf("rnd%0d", c), m_sel, m_done, m_forced, m_busy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
